bus_invert_enc: RTL and testbench

BUS_INVERT_ENC -- requirements
Module: bus_invert_enc

---
 rtl/bus_invert_enc_pkg.sv | 13 +
 rtl/bus_invert_enc_popcount.sv | 20 ++
 rtl/bus_invert_enc.sv | 82 ++++++++
 tb/tb_bus_invert_enc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_invert_enc_pkg.sv
// Shared constants and helpers for the bus-invert encoder.
package bus_invert_enc_pkg;

  // Default data word width and inversion-counter width.
  localparam int DW_DEFAULT = 10;
  localparam int CW_DEFAULT = 16;

  // Number of bits needed to hold a popcount of a dw-bit word (0..dw).
  function automatic int pc_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/bus_invert_enc_popcount.sv
// Combinational population count of a DW-bit word.
module popcount
  import bus_invert_enc_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  localparam int PW = pc_width(DW)
) (
  input  logic [DW-1:0] din,
  output logic [PW-1:0] cnt
);

  // Sum the set bits; synthesis folds this into an adder tree.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DW; i++) begin
      cnt = cnt + PW'(din[i]);
    end
  end

endmodule

// File: rtl/bus_invert_enc.sv
// Bus-invert encoder: a 1-deep output register that inverts a word whenever
// that flips fewer bus lines than sending it raw, with a saturating counter
// of inverted words delivered downstream.
module bus_invert_enc
  import bus_invert_enc_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bi_en,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_inv,
  output logic [CW-1:0] inv_count
);

  localparam int PW = pc_width(DW);
  // Invert only when strictly more than half the lines would toggle.
  localparam logic [PW-1:0] HALF = PW'(DW / 2);

  logic [DW-1:0] data_reg;
  logic          inv_reg;
  logic          valid_reg;
  logic [CW-1:0] count_reg;

  logic [DW-1:0] diff;
  logic [PW-1:0] hd;
  logic          inv_next;
  logic          accept;
  logic          xfer;

  // The register stays loadable whenever it is empty or being drained.
  assign s_ready  = !valid_reg || m_ready;
  assign accept   = s_valid && s_ready;
  assign xfer     = valid_reg && m_ready;

  // Distance is measured against what is currently on the bus (data_reg),
  // which is kept after the word leaves so it remains the reference.
  assign diff     = s_data ^ data_reg;
  assign inv_next = bi_en && (hd > HALF);

  popcount #(.DW(DW)) u_popcount (
    .din (diff),
    .cnt (hd)
  );

  // Output register: load on acceptance, drop valid on a bare transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      inv_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else if (accept) begin
      data_reg  <= s_data ^ {DW{inv_next}};
      inv_reg   <= inv_next;
      valid_reg <= 1'b1;
    end else if (xfer) begin
      valid_reg <= 1'b0;
    end
  end

  // Count inverted words as they leave, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (xfer && inv_reg && (count_reg != '1)) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign m_valid   = valid_reg;
  assign m_data    = data_reg;
  assign m_inv     = inv_reg;
  assign inv_count = count_reg;

endmodule

// File: tb/tb_bus_invert_enc.sv
// Self-checking bench for bus_invert_enc: table of vectors plus hand-written
// backpressure, saturation and asynchronous-reset sequences, all checked
// through an expected-word scoreboard.
module tb_bus_invert_enc;

  localparam int DW = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bi_en;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_inv;
  logic [CW-1:0] inv_count;

  bus_invert_enc #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bi_en     (bi_en),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_inv     (m_inv),
    .inv_count (inv_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          inv;
  } exp_t;

  typedef struct {
    logic          bi_en;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_data;
    logic          exp_inv;
  } vec_t;

  exp_t          sb[$];
  vec_t          tbl[10];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] ref_data = '0;
  logic [CW-1:0] cnt_model = '0;
  bit            tbl_mode = 1'b0;
  bit            verbose = 1'b1;
  exp_t          tbl_exp;
  exp_t          held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t predict(input logic [DW-1:0] din, input logic en);
    exp_t e;
    int   hd;
    hd    = $countones(din ^ ref_data);
    e.inv = en && (hd > DW / 2);
    e.data = e.inv ? ~din : din;
    return e;
  endfunction

  // One clock: score the handshakes at the falling edge, then step to just
  // after the rising edge so the caller can drive the next inputs.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got unexpected word %0h, expected none", m_data);
      end else begin
        e = sb.pop_front();
        chk("m_data", 32'(m_data), 32'(e.data));
        chk("m_inv", 32'(m_inv), 32'(e.inv));
        if (e.inv && cnt_model != '1) cnt_model++;
        if (verbose) $display("xfer data=%03h inv=%0b count_model=%0d", m_data, m_inv, cnt_model);
      end
    end
    if (s_valid && s_ready) begin
      e = tbl_mode ? tbl_exp : predict(s_data, bi_en);
      ref_data = e.data;
      sb.push_back(e);
      if (verbose) $display("accept din=%03h bi_en=%0b -> exp %03h/%0b", s_data, bi_en, e.data, e.inv);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) cycle();
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", sb.size());
    end
    cycle();
  endtask

  initial begin
    tbl[0] = '{1'b1, 10'h3FF, 10'h000, 1'b1};
    tbl[1] = '{1'b1, 10'h01F, 10'h01F, 1'b0};
    tbl[2] = '{1'b0, 10'h3FF, 10'h3FF, 1'b0};
    tbl[3] = '{1'b1, 10'h000, 10'h3FF, 1'b1};
    tbl[4] = '{1'b1, 10'h3F0, 10'h3F0, 1'b0};
    tbl[5] = '{1'b1, 10'h00F, 10'h3F0, 1'b1};
    tbl[6] = '{1'b1, 10'h03F, 10'h3C0, 1'b1};
    tbl[7] = '{1'b1, 10'h3C1, 10'h3C1, 1'b0};
    tbl[8] = '{1'b1, 10'h03E, 10'h3C1, 1'b1};
    tbl[9] = '{1'b1, 10'h0C1, 10'h0C1, 1'b0};

    rst_n = 1'b0; bi_en = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #12;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_inv", 32'(m_inv), 32'd0);
    chk("rst_count", 32'(inv_count), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors streamed back to back at full rate.
    tbl_mode = 1'b1;
    m_ready  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      bi_en   = tbl[i].bi_en;
      s_data  = tbl[i].din;
      tbl_exp = '{tbl[i].exp_data, tbl[i].exp_inv};
      chk("stream_s_ready", 32'(s_ready), 32'd1);
      if (i > 0) chk("stream_m_valid", 32'(m_valid), 32'd1);
      cycle();
    end
    tbl_mode = 1'b0;
    drain();
    chk("table_count", 32'(inv_count), 32'd5);
    chk("table_m_valid", 32'(m_valid), 32'd0);
    chk("ref_retained", 32'(m_data), 32'h0C1);

    // Backpressure: one inverted word held while upstream keeps pushing.
    m_ready = 1'b0; s_valid = 1'b1; bi_en = 1'b1; s_data = ~ref_data;
    cycle();
    held = sb[0];
    s_data = 10'h155; bi_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_s_ready", 32'(s_ready), 32'd0);
      chk("bp_m_valid", 32'(m_valid), 32'd1);
      chk("bp_m_data", 32'(m_data), 32'(held.data));
      chk("bp_m_inv", 32'(m_inv), 32'(held.inv));
      bi_en = ~bi_en;
    end
    bi_en = 1'b0;
    m_ready = 1'b1;
    cycle();
    chk("bp_reload_valid", 32'(m_valid), 32'd1);
    drain();
    chk("bp_count", 32'(inv_count), 32'(cnt_model));

    // Saturation: a long run of words that always invert.
    verbose = 1'b0;
    bi_en = 1'b1; m_ready = 1'b1; s_valid = 1'b1; s_data = ~ref_data;
    for (int i = 0; i < 65540; i++) cycle();
    drain();
    chk("sat_count", 32'(inv_count), 32'hFFFF);
    chk("sat_model", 32'(inv_count), 32'(cnt_model));
    verbose = 1'b1;
    s_valid = 1'b1; s_data = ~ref_data;
    cycle();
    drain();
    chk("sat_hold", 32'(inv_count), 32'hFFFF);

    // Asynchronous reset while a word is held.
    m_ready = 1'b0; s_valid = 1'b1; s_data = 10'h2A5;
    cycle();
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    chk("arst_m_data", 32'(m_data), 32'd0);
    chk("arst_m_inv", 32'(m_inv), 32'd0);
    chk("arst_count", 32'(inv_count), 32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd1);
    sb.delete();
    ref_data = '0;
    cnt_model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First post-reset word is measured against zero.
    m_ready = 1'b1; s_valid = 1'b1; bi_en = 1'b1; s_data = 10'h3FF;
    cycle();
    chk("post_m_data", 32'(m_data), 32'd0);
    chk("post_m_inv", 32'(m_inv), 32'd1);
    drain();
    chk("post_count", 32'(inv_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
